// File: rtl/crg_pkg.sv
// Shared clock/reset-generation types: sequencer state encoding and default widths.
package crg_pkg;

   typedef enum logic [1:0] {
      SEQ_IDLE,
      SEQ_COUNT,
      SEQ_DONE
   } seq_state_e;

   localparam int CRG_CNT_W = 8;

endpackage

// File: rtl/rst_seq_cnt.sv
// Loadable down-counter that stops at zero; zero_o flags the terminal count.
module rst_seq_cnt #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_i,
   input  logic [CNT_W-1:0] load_val_i,
   output logic             zero_o
);

   logic [CNT_W-1:0] cnt_q;

   // Load wins over decrement; decrement is gated at zero so the count never wraps.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else if (load_i) begin
         cnt_q <= load_val_i;
      end else if (cnt_q != '0) begin
         cnt_q <= cnt_q - CNT_W'(1);
      end
   end

   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/rst_seq_ctrl.sv
// Reset-release sequencer: deasserts NUM_DOMAINS active-low domain resets one at a
// time in index order, each after its own latched cycle delay.
module rst_seq_ctrl
   import crg_pkg::*;
#(
   parameter int NUM_DOMAINS = 4,
   parameter int CNT_W       = CRG_CNT_W
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           start_i,
   input  logic                           abort_i,
   input  logic [NUM_DOMAINS*CNT_W-1:0]   dly_i,
   output logic [NUM_DOMAINS-1:0]         rst_n_o,
   output logic                           busy_o,
   output logic                           done_o,
   output logic [$clog2(NUM_DOMAINS)-1:0] stage_o,
   output seq_state_e                     dbg_state_o
);

   localparam int               STG_W    = $clog2(NUM_DOMAINS);
   localparam int               LAST     = NUM_DOMAINS - 1;
   localparam logic [STG_W-1:0] LAST_STG = STG_W'(LAST);

   seq_state_e       state_q;
   logic [STG_W-1:0] stage_q;
   logic [CNT_W-1:0] dly_q [NUM_DOMAINS];

   logic             cnt_zero;
   logic             cnt_load;
   logic [CNT_W-1:0] cnt_val;
   logic [CNT_W-1:0] nxt_dly;
   logic             release_now;

   // Delay for the stage that follows the one currently being timed.
   always_comb begin
      nxt_dly = '0;
      for (int k = 0; k < LAST; k++) begin
         if (stage_q == STG_W'(k)) begin
            nxt_dly = dly_q[k+1];
         end
      end
   end

   assign release_now = (state_q == SEQ_COUNT) && cnt_zero;

   // Stage 0 loads straight from dly_i because dly_q is being written on the same edge.
   always_comb begin
      cnt_load = 1'b0;
      cnt_val  = '0;
      if (abort_i) begin
         cnt_load = 1'b1;
      end else if ((state_q == SEQ_IDLE) && start_i) begin
         cnt_load = 1'b1;
         cnt_val  = dly_i[CNT_W-1:0];
      end else if (release_now && (stage_q != LAST_STG)) begin
         cnt_load = 1'b1;
         cnt_val  = nxt_dly;
      end
   end

   rst_seq_cnt #(
      .CNT_W (CNT_W)
   ) u_cnt (
      .clk        (clk),
      .rst        (rst),
      .load_i     (cnt_load),
      .load_val_i (cnt_val),
      .zero_o     (cnt_zero)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= SEQ_IDLE;
         stage_q <= '0;
         rst_n_o <= '0;
         for (int k = 0; k < NUM_DOMAINS; k++) begin
            dly_q[k] <= '0;
         end
      end else if (abort_i) begin
         state_q <= SEQ_IDLE;
         stage_q <= '0;
         rst_n_o <= '0;
      end else begin
         case (state_q)
            SEQ_IDLE: begin
               if (start_i) begin
                  for (int k = 0; k < NUM_DOMAINS; k++) begin
                     dly_q[k] <= dly_i[k*CNT_W +: CNT_W];
                  end
                  stage_q <= '0;
                  state_q <= SEQ_COUNT;
               end
            end
            SEQ_COUNT: begin
               if (cnt_zero) begin
                  rst_n_o[stage_q] <= 1'b1;
                  if (stage_q == LAST_STG) begin
                     state_q <= SEQ_DONE;
                  end else begin
                     stage_q <= stage_q + STG_W'(1);
                  end
               end
            end
            SEQ_DONE: begin
               state_q <= SEQ_DONE;
            end
            default: begin
               state_q <= SEQ_IDLE;
            end
         endcase
      end
   end

   assign busy_o      = (state_q == SEQ_COUNT);
   assign done_o      = (state_q == SEQ_DONE);
   assign stage_o     = stage_q;
   assign dbg_state_o = state_q;

endmodule
